// File: rtl/bitonic_merger_pipe_if.sv
// Streaming beat channel for the bitonic merger: valid/ready handshake plus
// a per-beat sort direction and a packed vector of SIZE elements.
interface bitonic_merger_pipe_if #(
  parameter int SIZE      = 8,
  parameter int ELEM_BITS = 8
);
  logic                      valid;
  logic                      ready;
  logic                      dir;
  logic [SIZE*ELEM_BITS-1:0] data;

  modport master (output valid, dir, data, input ready);
  modport slave  (input valid, dir, data, output ready);
endinterface

// File: rtl/bitonic_merger_pipe.sv
// Pipelined bitonic half-cleaner: one compare-exchange level per register
// stage, merging a bitonic beat into a sorted one at one beat per cycle.
module bitonic_merger_cas #(
  parameter int KEY_BITS  = 8,
  parameter int ELEM_BITS = 8
) (
  input  logic                 dir_i,
  input  logic [ELEM_BITS-1:0] a_i,
  input  logic [ELEM_BITS-1:0] b_i,
  output logic [ELEM_BITS-1:0] lo_o,
  output logic [ELEM_BITS-1:0] hi_o
);
  logic [KEY_BITS-1:0] ka, kb;
  logic                swap;

  assign ka = a_i[ELEM_BITS-1 -: KEY_BITS];
  assign kb = b_i[ELEM_BITS-1 -: KEY_BITS];
  // Strict compares: equal keys stay put so payload order is preserved.
  assign swap = dir_i ? (ka < kb) : (ka > kb);
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;
endmodule

module bitonic_merger_pipe #(
  parameter int KEY_BITS     = 8,
  parameter int PAYLOAD_BITS = 0,
  parameter int DEPTH        = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  bitonic_merger_pipe_if.slave       in_if,
  bitonic_merger_pipe_if.master      out_if,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int SIZE      = 1 << DEPTH;
  localparam int ELEM_BITS = KEY_BITS + PAYLOAD_BITS;
  localparam int OCC_W     = $clog2(DEPTH+1);

  typedef logic [SIZE-1:0][ELEM_BITS-1:0] beat_t;

  logic             adv;
  logic [DEPTH:1]   vld_q, dir_q;
  logic [DEPTH-1:0] vld_d, dir_d;
  beat_t            stg_in [DEPTH];
  beat_t            dat_d  [DEPTH];
  beat_t            dat_q  [1:DEPTH];

  // Whole pipe moves in lockstep; no bubble collapse.
  assign adv         = out_if.ready | ~vld_q[DEPTH];
  assign in_if.ready = adv;

  assign out_if.valid = vld_q[DEPTH];
  assign out_if.dir   = dir_q[DEPTH];
  assign out_if.data  = dat_q[DEPTH];

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    localparam int H = SIZE >> (s + 1);

    if (s == 0) begin : g_head
      assign stg_in[s] = in_if.data;
      assign vld_d[s]  = in_if.valid;
      assign dir_d[s]  = in_if.dir;
    end else begin : g_body
      assign stg_in[s] = dat_q[s];
      assign vld_d[s]  = vld_q[s];
      assign dir_d[s]  = dir_q[s];
    end

    // Pair p maps to lower index I inside its 2H-wide block, partner I+H.
    for (genvar p = 0; p < SIZE/2; p++) begin : g_pair
      localparam int I = (p / H) * 2 * H + (p % H);
      bitonic_merger_cas #(.KEY_BITS(KEY_BITS), .ELEM_BITS(ELEM_BITS)) u_cas (
        .dir_i (dir_d[s]),
        .a_i   (stg_in[s][I]),
        .b_i   (stg_in[s][I+H]),
        .lo_o  (dat_d[s][I]),
        .hi_o  (dat_d[s][I+H])
      );
    end

    if (s == DEPTH-1) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (rst)      dat_q[s+1] <= '0;
        else if (adv) dat_q[s+1] <= dat_d[s];
      end
    end else begin : g_mid_reg
      always_ff @(posedge clk) begin
        if (adv) dat_q[s+1] <= dat_d[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dir_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 1; k <= DEPTH; k++) occupancy = occupancy + OCC_W'(vld_q[k]);
  end
endmodule

// File: tb/tb_bitonic_merger_pipe.sv
// Scoreboard bench for bitonic_merger_pipe: expected beats come from a plain
// sort of the input elements and are checked by an independent monitor.
module tb_bitonic_merger_pipe;
  localparam int KB    = 8;
  localparam int PB    = 4;
  localparam int DEPTH = 3;
  localparam int SIZE  = 1 << DEPTH;
  localparam int EB    = KB + PB;
  localparam int W     = SIZE * EB;

  typedef int arr_t [SIZE];
  typedef struct { logic dir; logic [W-1:0] data; } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] occ;
  always #5 clk = ~clk;

  bitonic_merger_pipe_if #(.SIZE(SIZE), .ELEM_BITS(EB)) in_if ();
  bitonic_merger_pipe_if #(.SIZE(SIZE), .ELEM_BITS(EB)) out_if ();

  bitonic_merger_pipe #(.KEY_BITS(KB), .PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (in_if),
    .out_if    (out_if),
    .occupancy (occ)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  exp_t e;
  logic stall_prev = 1'b0;
  logic stall_dir;
  logic [W-1:0] stall_data;
  logic done = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input arr_t k, input arr_t p);
    logic [W-1:0] v = '0;
    for (int i = 0; i < SIZE; i++) v[i*EB +: EB] = {k[i][KB-1:0], p[i][PB-1:0]};
    return v;
  endfunction

  // Reference: sort elements by key in the requested direction.
  function automatic logic [W-1:0] model(input arr_t k, input arr_t p, input logic d);
    arr_t kk = k;
    arr_t pp = p;
    int   t;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE-1-i; j++)
        if (d ? (kk[j] < kk[j+1]) : (kk[j] > kk[j+1])) begin
          t = kk[j]; kk[j] = kk[j+1]; kk[j+1] = t;
          t = pp[j]; pp[j] = pp[j+1]; pp[j+1] = t;
        end
    return pack(kk, pp);
  endfunction

  // Distinct keys, rising then falling, rotated: a bitonic sequence.
  task automatic rand_bitonic(output arr_t k, output arr_t p);
    bit   used [256];
    arr_t s, f, b, seq;
    int   v, t, nf, nb, r;
    for (int i = 0; i < 256; i++) used[i] = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      do v = int'($urandom_range(0, 255)); while (used[v]);
      used[v] = 1'b1;
      s[i] = v;
    end
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE-1-i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    nf = 0; nb = 0;
    for (int i = 0; i < SIZE; i++)
      if ($urandom_range(0, 1) == 1) begin f[nf] = s[i]; nf++; end
      else begin b[nb] = s[i]; nb++; end
    for (int i = 0; i < nf; i++) seq[i] = f[i];
    for (int i = 0; i < nb; i++) seq[nf+i] = b[nb-1-i];
    r = int'($urandom_range(0, SIZE-1));
    for (int i = 0; i < SIZE; i++) begin
      k[(i+r)%SIZE] = seq[i];
      p[i] = int'($urandom_range(0, 15));
    end
  endtask

  task automatic send(input logic d, input logic [W-1:0] data, input logic [W-1:0] exp);
    int n = 0;
    in_if.valid = 1'b1;
    in_if.dir   = d;
    in_if.data  = data;
    @(negedge clk);
    while (!in_if.ready && n < 200) begin @(negedge clk); n++; end
    if (!in_if.ready) begin
      checks++; errors++;
      $display("FAIL send_timeout got=in_ready0 exp=accept");
    end else sb.push_back('{dir: d, data: exp});
    @(posedge clk); #1;
    in_if.valid = 1'b0;
  endtask

  task automatic send_rand(input logic d);
    arr_t k, p;
    rand_bitonic(k, p);
    send(d, pack(k, p), model(k, p, d));
  endtask

  task automatic lat_check(input string name);
    int n = 1;
    while (!out_if.valid && n < 20) begin @(posedge clk); #1; n++; end
    chk(name, W'(n), W'(DEPTH));
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    #1;
    chk(name, W'(sb.size()), '0);
  endtask

  // Monitor: pops on every output handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        chk("stall_valid", W'(out_if.valid), W'(1));
        chk("stall_data", out_if.data, stall_data);
        chk("stall_dir", W'(out_if.dir), W'(stall_dir));
      end
      if (out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat got=%h exp=none", out_if.data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_if.data, e.data);
          chk("sb_dir", W'(out_if.dir), W'(e.dir));
        end
      end
      stall_prev = out_if.valid && !out_if.ready;
      stall_data = out_if.data;
      stall_dir  = out_if.dir;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arr_t k, p, ek, ep;
    in_if.valid  = 1'b0;
    in_if.dir    = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_if.valid), '0);
    chk("rst_out_data", out_if.data, '0);
    chk("rst_out_dir", W'(out_if.dir), '0);
    chk("rst_occ", W'(occ), '0);
    chk("rst_in_ready", W'(in_if.ready), W'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    k = '{1, 4, 6, 9, 8, 5, 3, 2};
    p = '{0, 1, 2, 3, 4, 5, 6, 7};
    send(1'b0, pack(k, p), model(k, p, 1'b0));
    lat_check("lat_asc");
    wait_empty("drain_asc");
    send(1'b1, pack(k, p), model(k, p, 1'b1));
    lat_check("lat_desc");
    wait_empty("drain_desc");

    // Equal keys must keep their payload order.
    k  = '{5, 5, 7, 7, 6, 6, 5, 5};
    ek = '{5, 5, 5, 5, 6, 6, 7, 7};
    ep = '{0, 1, 6, 7, 4, 5, 2, 3};
    send(1'b0, pack(k, p), pack(ek, ep));
    wait_empty("drain_stable");

    for (int i = 0; i < 10; i++) begin
      send_rand(i[0]);
      if (i >= 2) chk("occ_steady", W'(occ), W'(DEPTH));
    end
    wait_empty("drain_b2b");

    out_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(i[0]);
    chk("bp_in_ready", W'(in_if.ready), '0);
    chk("bp_occ", W'(occ), W'(DEPTH));
    repeat (5) @(posedge clk);
    #1;
    chk("bp_occ_hold", W'(occ), W'(DEPTH));
    chk("bp_valid_hold", W'(out_if.valid), W'(1));
    out_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) send_rand(~i[0]);
    wait_empty("drain_bp");

    send_rand(1'b0);
    send_rand(1'b1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid_out_valid", W'(out_if.valid), '0);
    chk("rstmid_occ", W'(occ), '0);
    repeat (8) @(posedge clk);
    #1;
    send_rand(1'b1);
    lat_check("lat_post_rst");
    wait_empty("drain_rst");

    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send_rand(1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_if.ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_if.ready = 1'b1;
    wait_empty("drain_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bitonic_merger_pipe.md
Name: bitonic_merger_pipe

Overview:
- Pipelined bitonic half-cleaner network that merges one bitonic sequence of SIZE = 2^DEPTH key/payload elements into a fully sorted sequence.
- Direction is selectable per beat at runtime.
- Fully flattened: one register stage per compare level, throughput one beat per cycle.
- Valid/ready handshake with backpressure; building block for the streaming sorter top level.

Parameters:
- KEY_BITS, 8, width of the compare key per element
- PAYLOAD_BITS, 0, width of the payload carried with each key; 0 means key-only
- DEPTH, 3, log2 of element count; legal range 1..8
- SIZE, 1 << DEPTH, element count; derived, never overridden
- ELEM_BITS, KEY_BITS + PAYLOAD_BITS, derived element width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  merger accepts a beat this cycle
- in_dir  input  1  0 = ascending (element 0 smallest), 1 = descending
- in_data  input  SIZE*ELEM_BITS  element i at bits [i*ELEM_BITS +: ELEM_BITS]; key in the upper KEY_BITS, payload in the lower PAYLOAD_BITS
- out_valid  output  1  sorted beat present
- out_ready  input  1  downstream accepts
- out_dir  output  1  direction the beat was merged with
- out_data  output  SIZE*ELEM_BITS  sorted elements, same packing as in_data
- occupancy  output  $clog2(DEPTH+1)  number of valid beats held in the pipeline

Behaviour:
- One clock domain, clk; rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - All stage valid bits, out_valid and occupancy go to 0.
  - out_data and out_dir go to 0.
  - Data registers inside the pipeline need no reset.
  - Reset asserted mid-operation discards all in-flight beats. No beat is emitted until a new beat is accepted after reset deasserts.
- Pipeline: DEPTH register stages, s = 0..DEPTH-1. The stage-(DEPTH-1) register drives out_* directly.
- Compare rule at stage s:
  - Half distance h = SIZE >> (s+1).
  - For every i with (i & h) == 0, compare key[i] against key[i+h].
  - ascending: swap if key[i] > key[i+h].
  - descending: swap if key[i] < key[i+h].
  - Keys are compared unsigned. Equal keys never swap, so payloads stay in place.
  - The payload moves with its key.
  - The dir bit travels with the beat; it does not come from a static parameter.
- Advance: advance = out_ready | ~out_valid. The whole pipe shifts only when advance is 1. There is no per-stage bubble collapse.
- in_ready = advance, combinational from out_ready and out_valid.
- Accept: a beat is accepted when in_valid & in_ready. When advance = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- Latency: exactly DEPTH cycles from acceptance to out_valid when out_ready is held 1.
- Stall hold: while out_valid = 1 and out_ready = 0, out_data, out_dir and out_valid must hold stable and every stage holds.
- Occupancy:
  - occupancy = sum of stage valid bits.
  - It increments on accept without a simultaneous output handshake, decrements on an output handshake without accept, and is unchanged when both or neither occur.
  - It never exceeds DEPTH.
- Input contract: in_data must be bitonic. Non-bitonic input produces a deterministic network output, which need not be sorted. No error is flagged.
- DEPTH = 1: a single compare-exchange stage; latency 1.

Test Plan:
- DEPTH=3, KEY_BITS=8, PAYLOAD_BITS=0, out_ready=1, in_dir=0, in_data elements 0..7 = [1,4,6,9,8,5,3,2] -> 3 cycles later out_valid=1, out_data=[1,2,3,4,5,6,8,9], out_dir=0.
- Same input with in_dir=1 -> out_data=[9,8,6,5,4,3,2,1], out_dir=1.
- Back-to-back beats, alternating dir, 10 cycles, out_ready=1 -> 10 sorted outputs on consecutive cycles in order, each with its own dir; occupancy holds at 3 during steady state.
- Backpressure: fill the pipe, then drop out_ready for 5 cycles -> in_ready=0, out_data stable, occupancy=3; raise out_ready -> beats drain in order with none lost or duplicated.
- Stability: PAYLOAD_BITS=4, keys [5,5,7,7,6,6,5,5] with payloads [0..7], ascending -> equal keys keep their relative payload order, for example key 5 payloads appear in the order 0,1,6,7.
- Reset with 2 beats in flight -> the cycle after rst, out_valid=0 and occupancy=0; no stale beat appears afterwards, and the first post-reset beat emerges after exactly DEPTH cycles.
